lcd_spi_writer: RTL and testbench
=================================

Name: lcd_spi_writer

Overview:
- Downstream byte serializer for the ST7789-class SPI LCD.
- Accepts 9-bit words {dc, byte} from the init sequencer or the pixel/image source, and shifts each word out as an SPI mode-0 byte.
- Returns a one-cycle wr_done strobe per completed byte; upstream uses it to advance to the next word.
- Level-driven: while en_write stays high, bytes stream back-to-back.

Parameters:
- SCLK_HALF_DIV, 2: clk_50MHz cycles per sclk half-period (sclk = 50MHz / (2*SCLK_HALF_DIV)); legal range 1..255.
- GAP_CYCLES, 2: idle clocks after wr_done before the next word is sampled. Gives upstream time to update its counter and ROM output. Legal range 1..255.

Ports:
- clk_50MHz  in  1  system clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk_50MHz
- data  in  9  [8]=dc (0 command, 1 data), [7:0]=byte; sampled only in LOAD
- en_write  in  1  level request; high = keep transferring
- wr_done  out  1  one-cycle pulse, byte fully shifted
- busy  out  1  high from LOAD through end of GAP
- cs  out  1  LCD chip select, active-low
- dc  out  1  data/command line, latched per byte
- sclk  out  1  SPI clock, idle low
- mosi  out  1  SPI data, MSB first

Behaviour:
- All outputs are registered.
- Reset values: cs=1, sclk=0, mosi=0, dc=0, wr_done=0, busy=0; state=IDLE; counters=0.
- States: IDLE, LOAD, SHIFT, DONE, GAP.
- IDLE:
  - Outputs: cs=1, sclk=0.
  - en_write sampled high → LOAD.
- LOAD (1 clk):
  - shift_reg<=data[7:0], dc<=data[8], cs<=0, mosi<=data[7], busy<=1.
  - bit_cnt<=0, div_cnt<=0; → SHIFT.
- SHIFT:
  - div_cnt counts 0..SCLK_HALF_DIV-1; at terminal count sclk toggles.
  - Rising edge: LCD samples mosi.
  - Falling edge: bit_cnt increments; mosi<=next bit.
  - After the 8th falling edge (16 half-periods total) → DONE; mosi holds the last bit.
- DONE (1 clk): wr_done=1; → GAP.
- GAP:
  - Count GAP_CYCLES clocks. cs stays low.
  - At end: en_write high → LOAD (back-to-back); else → IDLE (cs<=1, busy<=0).
- Timing:
  - wr_done rises 2+16*SCLK_HALF_DIV clocks after the IDLE edge that sampled en_write.
  - Steady-state byte period = 2+16*SCLK_HALF_DIV+GAP_CYCLES clocks (36 at defaults).
- Boundaries:
  - data changes outside LOAD are ignored; dc and the byte are stable for the whole transfer.
  - en_write falling mid-byte: the byte completes, wr_done pulses once, then IDLE after GAP. No truncated bytes are ever emitted.
  - en_write high for a single cycle in IDLE: exactly one byte is sent.
  - en_write is ignored in LOAD/SHIFT/DONE; it is sampled only in IDLE and at the end of GAP.
  - Reset mid-operation: outputs return to reset values immediately, no wr_done is emitted, and the partial byte is discarded.
  - The sclk high and low phases are always equal, SCLK_HALF_DIV clocks each.

Optional Feature:
- Macro: LCD_SPI_CS_TOGGLE_EN.
- Defined: cs returns high for the whole GAP after every byte and drops again in LOAD. Gives per-byte framing for panels that need it. The byte period is unchanged.
- Undefined: cs stays low across back-to-back bytes and rises only on the GAP→IDLE transition.

Decomposition:
- Package lcd_spi_pkg:
  - State enum (IDLE, LOAD, SHIFT, DONE, GAP).
  - Default constants: SCLK_HALF_DIV=2, GAP_CYCLES=2.
  - Bit-count width constant (3 bits); dc bit index 8.
  - Shared with the init sequencer and the image display so their pacing assumptions use the same constants.
- One natural sub-module: lcd_spi_sclk_gen, holding the divider counter plus registered sclk, rise strobe and fall strobe. It is enabled only in SHIFT and cleared in LOAD.

Test Plan:
- Reset: assert rst_n=0 mid-run → cs=1, sclk=0, mosi=0, dc=0, wr_done=0, busy=0 within the same cycle (async); hold 5 clks, release, and confirm IDLE.
- Single byte: data=9'h0A5, en_write high 1 clk → dc=0; mosi on the 8 sclk rising edges = 1,0,1,0,0,1,0,1; wr_done pulses once, 34 clks after the sample edge; cs=1 after GAP.
- Back-to-back: en_write held high; data=9'h12C, updated to 9'h1FF on wr_done → bytes 0x2C then 0xFF, dc=1 both; cs low throughout; wr_done period 36 clks.
- Mid-byte drop: en_write falls at the 3rd sclk rise of byte 9'h155 → full 0x55 is shifted, exactly one wr_done, IDLE with cs=1 at 36 clks.
- Divider sweep: SCLK_HALF_DIV=1, GAP_CYCLES=1 → sclk=25MHz with 50% duty; byte period 19 clks; no glitch on sclk.
- With LCD_SPI_CS_TOGGLE_EN: back-to-back stream 9'h011, 9'h022 → cs high for exactly GAP_CYCLES clks between bytes; data is bit-identical to the undefined build.

Source files
------------

// File: rtl/lcd_spi_pkg.sv
// Shared constants and state encoding for the ST7789 SPI byte writer and the
// blocks that pace their traffic against it (init sequencer, image source).
package lcd_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE,
    GAP
  } state_t;

  localparam int SCLK_HALF_DIV_DEF = 2;
  localparam int GAP_CYCLES_DEF    = 2;

  localparam int BIT_CNT_W = 3;
  localparam int DIV_CNT_W = 8;
  localparam int DC_BIT    = 8;

endpackage

// File: rtl/lcd_spi_sclk_gen.sv
// SPI clock divider: registered sclk plus look-ahead rise/fall strobes that are
// high during the clock whose closing edge moves sclk up/down.
module lcd_spi_sclk_gen
  import lcd_spi_pkg::*;
#(
  parameter int HALF_DIV = SCLK_HALF_DIV_DEF
) (
  input  logic clk_50MHz,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam logic [DIV_CNT_W-1:0] TERM   = DIV_CNT_W'(HALF_DIV - 1);
  localparam logic                 SINGLE = (HALF_DIV == 1);

  logic [DIV_CNT_W-1:0] div_cnt;
  logic [DIV_CNT_W-1:0] div_inc;

  assign div_inc = div_cnt + DIV_CNT_W'(1);

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else if (clr) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
      rise    <= SINGLE;
      fall    <= 1'b0;
    end else if (en) begin
      if (div_cnt == TERM) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        // With a one-clock half period the opposite edge is due immediately.
        rise    <= SINGLE & sclk;
        fall    <= SINGLE & ~sclk;
      end else begin
        div_cnt <= div_inc;
        rise    <= (div_inc == TERM) & ~sclk;
        fall    <= (div_inc == TERM) & sclk;
      end
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_spi_writer.sv
// SPI mode-0 byte serializer for the ST7789 panel: {dc, byte} in, one wr_done per byte.
// LCD_SPI_CS_TOGGLE_EN: release cs for the whole inter-byte gap instead of holding it low.
module lcd_spi_writer
  import lcd_spi_pkg::*;
#(
  parameter int SCLK_HALF_DIV = SCLK_HALF_DIV_DEF,
  parameter int GAP_CYCLES    = GAP_CYCLES_DEF
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic [8:0] data,
  input  logic       en_write,
  output logic       wr_done,
  output logic       busy,
  output logic       cs,
  output logic       dc,
  output logic       sclk,
  output logic       mosi
);

  localparam logic [7:0] GAP_TERM = 8'(GAP_CYCLES - 1);

  state_t               state;
  logic [7:0]           shift_reg;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           gap_cnt;
  logic                 in_shift;
  logic                 in_load;
  logic                 sclk_rise;
  logic                 sclk_fall;

  assign in_shift = (state == SHIFT);
  assign in_load  = (state == LOAD);

  lcd_spi_sclk_gen #(
    .HALF_DIV (SCLK_HALF_DIV)
  ) u_sclk_gen (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .en        (in_shift),
    .clr       (in_load),
    .sclk      (sclk),
    .rise      (sclk_rise),
    .fall      (sclk_fall)
  );

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      cs        <= 1'b1;
      mosi      <= 1'b0;
      dc        <= 1'b0;
      wr_done   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          cs <= 1'b1;
          if (en_write) state <= LOAD;
        end
        LOAD: begin
          shift_reg <= data[7:0];
          dc        <= data[DC_BIT];
          mosi      <= data[7];
          cs        <= 1'b0;
          busy      <= 1'b1;
          bit_cnt   <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          // The panel latches on the rise; the next bit is presented on the fall.
          if (sclk_rise) shift_reg <= {shift_reg[6:0], 1'b0};
          if (sclk_fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (&bit_cnt) state <= DONE;
            else          mosi  <= shift_reg[7];
          end
        end
        DONE: begin
          wr_done <= 1'b1;
          gap_cnt <= '0;
          state   <= GAP;
`ifdef LCD_SPI_CS_TOGGLE_EN
          cs      <= 1'b1;
`else
          cs      <= 1'b0;
`endif
        end
        GAP: begin
          if (gap_cnt == GAP_TERM) begin
            if (en_write) begin
              // Dropping cs here keeps its high time equal to the gap length.
              cs    <= 1'b0;
              state <= LOAD;
            end else begin
              cs    <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Bench for lcd_spi_writer: a default instance and a fast (1,1) instance, with a
// bus monitor that rebuilds the bytes seen on the SPI pins.
module tb_lcd_spi_writer;

  localparam int DIV0 = 2;
  localparam int GAP0 = 2;
  localparam int DIV1 = 1;
  localparam int GAP1 = 1;
`ifdef LCD_SPI_CS_TOGGLE_EN
  localparam bit CS_TOGGLE = 1'b1;
`else
  localparam bit CS_TOGGLE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] data0, data1;
  logic [1:0] en;
  logic [1:0] wr_done, busy, cs, dc, sclk, mosi;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  lcd_spi_writer u_dut (
    .clk_50MHz (clk), .rst_n (rst_n), .data (data0), .en_write (en[0]),
    .wr_done (wr_done[0]), .busy (busy[0]), .cs (cs[0]), .dc (dc[0]),
    .sclk (sclk[0]), .mosi (mosi[0])
  );

  lcd_spi_writer #(.SCLK_HALF_DIV(DIV1), .GAP_CYCLES(GAP1)) u_fast (
    .clk_50MHz (clk), .rst_n (rst_n), .data (data1), .en_write (en[1]),
    .wr_done (wr_done[1]), .busy (busy[1]), .cs (cs[1]), .dc (dc[1]),
    .sclk (sclk[1]), .mosi (mosi[1])
  );

  initial forever #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int div_of(input int k);
    return (k == 0) ? DIV0 : DIV1;
  endfunction
  function automatic int gap_of(input int k);
    return (k == 0) ? GAP0 : GAP1;
  endfunction
  function automatic int latency(input int k);
    return 2 + 16 * div_of(k);
  endfunction
  function automatic int period(input int k);
    return 2 + 16 * div_of(k) + gap_of(k);
  endfunction
  function automatic int cs_release(input int k);
    return CS_TOGGLE ? latency(k) : period(k);
  endfunction
  function automatic int cs_gap(input int k);
    return CS_TOGGLE ? gap_of(k) : 0;
  endfunction

  // Bus monitor
  logic [8:0] got_word [2][64];
  int         got_bits [2][64];
  int         got_time [2][64];
  int         got_cs   [2][64];
  int         got_n    [2];
  int         cs_cnt   [2];
  int         phase_bad[2];
  int         glitch   [2];
  int         mosi_bad [2];
  int         bit_n    [2];
  int         tog      [2];
  int         plen     [2];
  logic [7:0] cur_byte [2];
  logic       cur_dc   [2];
  logic [1:0] prev_sclk = 2'b00;
  logic [1:0] prev_mosi = 2'b00;

  initial begin
    for (int k = 0; k < 2; k++) begin
      got_n[k] = 0; cs_cnt[k] = 0; phase_bad[k] = 0; glitch[k] = 0;
      mosi_bad[k] = 0; bit_n[k] = 0; tog[k] = 0; plen[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n !== 1'b1) begin
        bit_n[k] = 0;
        tog[k]   = 0;
        plen[k]  = 0;
      end else begin
        plen[k] = plen[k] + 1;
        if (sclk[k] !== prev_sclk[k]) begin
          if (cs[k] !== 1'b0) glitch[k] = glitch[k] + 1;
          if (tog[k] > 0 && plen[k] != div_of(k)) phase_bad[k] = phase_bad[k] + 1;
          tog[k]  = tog[k] + 1;
          plen[k] = 0;
          if (sclk[k] === 1'b1) begin
            if (mosi[k] !== prev_mosi[k]) mosi_bad[k] = mosi_bad[k] + 1;
            cur_byte[k] = {cur_byte[k][6:0], mosi[k]};
            cur_dc[k]   = dc[k];
            bit_n[k]    = bit_n[k] + 1;
          end
        end
        if (wr_done[k] === 1'b1 && got_n[k] < 64) begin
          got_word[k][got_n[k]] = {cur_dc[k], cur_byte[k]};
          got_bits[k][got_n[k]] = bit_n[k];
          got_time[k][got_n[k]] = cyc;
          got_cs[k][got_n[k]]   = cs_cnt[k];
          got_n[k] = got_n[k] + 1;
          bit_n[k] = 0;
          tog[k]   = 0;
        end
        if (cs[k] === 1'b1) cs_cnt[k] = cs_cnt[k] + 1;
      end
      prev_sclk[k] = sclk[k];
      prev_mosi[k] = mosi[k];
    end
  end

  // Stream driver: holds en_write high and offers the next word on each wr_done
  logic [8:0] stream_w [8];
  int         st_n0;
  int         st_t0;

  task automatic set_data(input int k, input logic [8:0] w);
    if (k == 0) data0 = w;
    else        data1 = w;
  endtask

  task automatic run_stream(input int k, input int nw);
    int guard;
    st_n0 = got_n[k];
    @(negedge clk);
    set_data(k, stream_w[0]);
    en[k] = 1'b1;
    st_t0 = cyc + 1;
    for (int i = 0; i < nw; i++) begin
      @(negedge clk);
      guard = 0;
      while (wr_done[k] !== 1'b1 && guard < 400) begin
        @(negedge clk);
        guard++;
      end
      n_chk++;
      if (guard >= 400) begin
        n_fail++;
        $display("FAIL stream_timeout: dut %0d word %0d saw no wr_done in %0d cycles, want one", k, i, guard);
      end
      if (i + 1 < nw) set_data(k, stream_w[i + 1]);
      else            en[k] = 1'b0;
    end
    repeat (60) @(negedge clk);
  endtask

  task automatic test_reset();
    int n0;
    rst_n = 1'b0;
    data0 = '0;
    data1 = '0;
    en    = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({cs, sclk, mosi, dc, wr_done, busy} !== 12'b11_00_00_00_00_00) begin
      n_fail++;
      $display("FAIL reset_values: {cs,sclk,mosi,dc,wr_done,busy} got %b want %b",
               {cs, sclk, mosi, dc, wr_done, busy}, 12'b110000000000);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if ({cs, sclk, wr_done, busy} !== 8'b11_00_00_00) begin
      n_fail++;
      $display("FAIL idle_after_release: {cs,sclk,wr_done,busy} got %b want %b",
               {cs, sclk, wr_done, busy}, 8'b11000000);
    end
    data0 = 9'h1C3;
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    repeat (12) @(negedge clk);
    n_chk++;
    if ({cs[0], busy[0]} !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_run_active: {cs,busy} got %b want 01", {cs[0], busy[0]});
    end
    n0 = got_n[0];
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({cs[0], sclk[0], mosi[0], dc[0], wr_done[0], busy[0]} !== 6'b100000) begin
      n_fail++;
      $display("FAIL async_reset: {cs,sclk,mosi,dc,wr_done,busy} got %b want 100000",
               {cs[0], sclk[0], mosi[0], dc[0], wr_done[0], busy[0]});
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    n_chk++;
    if (got_n[0] !== n0) begin
      n_fail++;
      $display("FAIL no_done_after_reset: wr_done count got %0d want %0d", got_n[0], n0);
    end
    n_chk++;
    if ({cs[0], busy[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL idle_after_reset: {cs,busy} got %b want 10", {cs[0], busy[0]});
    end
  endtask

  task automatic test_single_byte();
    int n0, t0, cs_rise;
    n0 = got_n[0];
    @(negedge clk);
    data0 = 9'h0A5;
    en[0] = 1'b1;
    t0    = cyc + 1;
    @(negedge clk);
    en[0] = 1'b0;
    @(negedge clk);
    cs_rise = -1;
    for (int i = 0; i < 80; i++) begin
      data0 = 9'($urandom);
      @(negedge clk);
      if (cs_rise < 0 && cs[0] === 1'b1) cs_rise = cyc;
    end
    n_chk++;
    if (got_n[0] !== n0 + 1) begin
      n_fail++;
      $display("FAIL single_count: wr_done pulses got %0d want 1", got_n[0] - n0);
    end
    n_chk++;
    if (got_word[0][n0] !== 9'h0A5 || got_bits[0][n0] !== 8) begin
      n_fail++;
      $display("FAIL single_word: {dc,byte} got %h in %0d bits want 0a5 in 8 bits",
               got_word[0][n0], got_bits[0][n0]);
    end
    n_chk++;
    if (got_time[0][n0] - t0 !== latency(0)) begin
      n_fail++;
      $display("FAIL single_latency: got %0d clks want %0d", got_time[0][n0] - t0, latency(0));
    end
    n_chk++;
    if (cs_rise - t0 !== cs_release(0)) begin
      n_fail++;
      $display("FAIL single_cs_release: cs high at %0d clks want %0d", cs_rise - t0, cs_release(0));
    end
    n_chk++;
    if (busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_idle: busy got %b want 0", busy[0]);
    end
  endtask

  task automatic test_back_to_back();
    stream_w[0] = 9'h12C;
    stream_w[1] = 9'h1FF;
    run_stream(0, 2);
    n_chk++;
    if (got_n[0] !== st_n0 + 2 || got_word[0][st_n0] !== 9'h12C || got_word[0][st_n0 + 1] !== 9'h1FF) begin
      n_fail++;
      $display("FAIL b2b_words: got %0d words %h %h want 2 words 12c 1ff",
               got_n[0] - st_n0, got_word[0][st_n0], got_word[0][st_n0 + 1]);
    end
    n_chk++;
    if (got_time[0][st_n0] - st_t0 !== latency(0)) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d want %0d", got_time[0][st_n0] - st_t0, latency(0));
    end
    n_chk++;
    if (got_time[0][st_n0 + 1] - got_time[0][st_n0] !== period(0)) begin
      n_fail++;
      $display("FAIL b2b_period: got %0d want %0d",
               got_time[0][st_n0 + 1] - got_time[0][st_n0], period(0));
    end
    n_chk++;
    if (got_cs[0][st_n0 + 1] - got_cs[0][st_n0] !== cs_gap(0)) begin
      n_fail++;
      $display("FAIL b2b_cs_gap: cs high %0d clks between bytes want %0d",
               got_cs[0][st_n0 + 1] - got_cs[0][st_n0], cs_gap(0));
    end
  endtask

  task automatic test_cs_framing();
    stream_w[0] = 9'h011;
    stream_w[1] = 9'h022;
    run_stream(0, 2);
    n_chk++;
    if (got_word[0][st_n0] !== 9'h011 || got_word[0][st_n0 + 1] !== 9'h022) begin
      n_fail++;
      $display("FAIL frame_words: got %h %h want 011 022", got_word[0][st_n0], got_word[0][st_n0 + 1]);
    end
    n_chk++;
    if (got_cs[0][st_n0 + 1] - got_cs[0][st_n0] !== cs_gap(0)) begin
      n_fail++;
      $display("FAIL frame_cs_gap: cs high %0d clks want %0d",
               got_cs[0][st_n0 + 1] - got_cs[0][st_n0], cs_gap(0));
    end
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 6; i++) stream_w[i] = 9'($urandom);
    run_stream(0, 6);
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (got_word[0][st_n0 + i] !== stream_w[i] || got_bits[0][st_n0 + i] !== 8) begin
        n_fail++;
        $display("FAIL rand_word%0d: got %h in %0d bits want %h in 8 bits",
                 i, got_word[0][st_n0 + i], got_bits[0][st_n0 + i], stream_w[i]);
      end
    end
    for (int i = 1; i < 6; i++) begin
      n_chk++;
      if (got_time[0][st_n0 + i] - got_time[0][st_n0 + i - 1] !== period(0)) begin
        n_fail++;
        $display("FAIL rand_period%0d: got %0d want %0d", i,
                 got_time[0][st_n0 + i] - got_time[0][st_n0 + i - 1], period(0));
      end
    end
  endtask

  task automatic test_mid_drop();
    int   n0, t0, rises, cs_rise;
    logic p;
    n0 = got_n[0];
    @(negedge clk);
    data0 = 9'h155;
    en[0] = 1'b1;
    t0    = cyc + 1;
    rises = 0;
    cs_rise = -1;
    p = sclk[0];
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (sclk[0] === 1'b1 && p === 1'b0) rises++;
      p = sclk[0];
      if (rises >= 3) en[0] = 1'b0;
      if (cs_rise < 0 && i > 2 && cs[0] === 1'b1) cs_rise = cyc;
    end
    n_chk++;
    if (got_n[0] !== n0 + 1) begin
      n_fail++;
      $display("FAIL drop_count: wr_done pulses got %0d want 1", got_n[0] - n0);
    end
    n_chk++;
    if (got_word[0][n0] !== 9'h155 || got_bits[0][n0] !== 8) begin
      n_fail++;
      $display("FAIL drop_word: got %h in %0d bits want 155 in 8 bits", got_word[0][n0], got_bits[0][n0]);
    end
    n_chk++;
    if (cs_rise - t0 !== cs_release(0) || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_idle: cs high at %0d clks busy %b want %0d clks busy 0",
               cs_rise - t0, busy[0], cs_release(0));
    end
  endtask

  task automatic test_divider();
    for (int i = 0; i < 4; i++) stream_w[i] = 9'($urandom);
    run_stream(1, 4);
    n_chk++;
    if (got_time[1][st_n0] - st_t0 !== latency(1)) begin
      n_fail++;
      $display("FAIL fast_latency: got %0d want %0d", got_time[1][st_n0] - st_t0, latency(1));
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (got_word[1][st_n0 + i] !== stream_w[i] || got_bits[1][st_n0 + i] !== 8) begin
        n_fail++;
        $display("FAIL fast_word%0d: got %h in %0d bits want %h in 8 bits",
                 i, got_word[1][st_n0 + i], got_bits[1][st_n0 + i], stream_w[i]);
      end
    end
    for (int i = 1; i < 4; i++) begin
      n_chk++;
      if (got_time[1][st_n0 + i] - got_time[1][st_n0 + i - 1] !== period(1)) begin
        n_fail++;
        $display("FAIL fast_period%0d: got %0d want %0d", i,
                 got_time[1][st_n0 + i] - got_time[1][st_n0 + i - 1], period(1));
      end
    end
    n_chk++;
    if (got_cs[1][st_n0 + 1] - got_cs[1][st_n0] !== cs_gap(1)) begin
      n_fail++;
      $display("FAIL fast_cs_gap: got %0d want %0d", got_cs[1][st_n0 + 1] - got_cs[1][st_n0], cs_gap(1));
    end
  endtask

  task automatic test_signal_integrity();
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (phase_bad[k] !== 0) begin
        n_fail++;
        $display("FAIL sclk_duty_dut%0d: %0d phases not %0d clks, want 0", k, phase_bad[k], div_of(k));
      end
      n_chk++;
      if (glitch[k] !== 0) begin
        n_fail++;
        $display("FAIL sclk_glitch_dut%0d: %0d toggles with cs high, want 0", k, glitch[k]);
      end
      n_chk++;
      if (mosi_bad[k] !== 0) begin
        n_fail++;
        $display("FAIL mosi_setup_dut%0d: %0d bits changed on sclk rise, want 0", k, mosi_bad[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_cs_framing();
    test_random_stream();
    test_mid_drop();
    test_divider();
    test_signal_integrity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
